// File: rtl/reg_file_2r1w.sv
// 32-entry, 2-read/1-write register file with hardwired-zero entry and a
// same-cycle writeback-to-decode bypass on both read ports.

module reg_file_2r1w_entry #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module reg_file_2r1w #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  parameter int delay    = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_a,
  output logic [WIDTH-1:0]         rd_data_b
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  // The read-path gate delay is a simulation-only annotation; the
  // synthesizable model is zero-delay, so only sanity-check the value.
  if (delay < 0) begin : g_bad_delay
    $error("reg_file_2r1w: delay must be non-negative");
  end

  wr_req_t wr;
  logic    wr_live;
  logic [NREGS-1:0][WIDTH-1:0] regs;

  assign wr.en   = wr_en;
  assign wr.addr = wr_addr;
  assign wr.data = wr_data;
  // A write is architecturally live only out of reset and never to XZR.
  assign wr_live = wr.en && reset && (wr.addr != ZADDR);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_ff
      reg_file_2r1w_entry #(.WIDTH(WIDTH)) u_entry (
        .clk   (clk),
        .reset (reset),
        .we    (wr_live && (wr.addr == AW'(r))),
        .d     (wr.data),
        .q     (regs[r])
      );
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == ZADDR)                rd_data_a = '0;
    else if (wr_live && wr.addr == rd_addr_a) rd_data_a = wr.data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == ZADDR)                rd_data_b = '0;
    else if (wr_live && wr.addr == rd_addr_b) rd_data_b = wr.data;
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed and randomized checks for reg_file_2r1w against hand values and a
// behavioural register model.

module tb_reg_file_2r1w;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [4:0]   rd_addr_a, rd_addr_b;
  logic [W-1:0] rd_data_a, rd_data_b;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mdl [32];

  reg_file_2r1w #(.WIDTH(W), .NREGS(32), .ZERO_REG(31), .delay(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd30;
    tick();
    rd(5, 30);
    chk("reset_a", rd_data_a, '0);
    chk("reset_b", rd_data_b, '0);

    // Preload, then clear with a one-edge reset pulse
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 64'h1234; tick();
    wr_addr = 5'd30; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    wr_en = 1'b0;
    rd(5, 30);
    chk("preload_x5", rd_data_a, 64'h1234);
    chk("preload_x30", rd_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
    reset = 1'b0; tick();
    reset = 1'b1;
    rd(5, 30);
    chk("clear_x5", rd_data_a, '0);
    chk("clear_x30", rd_data_b, '0);

    // Write/readback
    wr_en = 1'b1; wr_addr = 5'd0;  wr_data = 64'hDEAD_BEEF_0000_0001; tick();
    wr_addr = 5'd17; wr_data = 64'h0123_4567_89AB_CDEF; tick();
    wr_en = 1'b0;
    rd(0, 17);
    chk("wr_x0", rd_data_a, 64'hDEAD_BEEF_0000_0001);
    chk("wr_x17", rd_data_b, 64'h0123_4567_89AB_CDEF);
    for (int r = 1; r < 32; r++) begin
      if (r != 17) begin
        rd(5'(r), 5'(r));
        chk($sformatf("others_a_x%0d", r), rd_data_a, '0);
        chk($sformatf("others_b_x%0d", r), rd_data_b, '0);
      end
    end

    // Zero register
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hAAAA_AAAA_AAAA_AAAA;
    rd(31, 0);
    chk("xzr_same_cycle", rd_data_a, '0);
    chk("xzr_x0_same_cycle", rd_data_b, 64'hDEAD_BEEF_0000_0001);
    tick();
    wr_en = 1'b0;
    rd(31, 17);
    chk("xzr_after", rd_data_a, '0);
    chk("xzr_x17_kept", rd_data_b, 64'h0123_4567_89AB_CDEF);
    rd(0, 30);
    chk("xzr_x0_kept", rd_data_a, 64'hDEAD_BEEF_0000_0001);
    chk("xzr_x30_kept", rd_data_b, '0);

    // Bypass
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd7; tick();
    wr_data = 64'd42;
    rd(9, 9);
    chk("byp_a_pre", rd_data_a, 64'd42);
    chk("byp_b_pre", rd_data_b, 64'd42);
    tick();
    wr_en = 1'b0; wr_data = 64'd99;
    rd(9, 9);
    chk("byp_a_post", rd_data_a, 64'd42);
    chk("byp_b_post", rd_data_b, 64'd42);

    // Reset collision: stored value shows during the reset cycle, not the bypass
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd11; tick();
    reset = 1'b0; wr_data = 64'd5;
    rd(3, 9);
    chk("rstcol_no_byp", rd_data_a, 64'd11);
    chk("rstcol_x9_pre", rd_data_b, 64'd42);
    tick();
    reset = 1'b1; wr_en = 1'b0;
    rd(3, 9);
    chk("rstcol_x3", rd_data_a, '0);
    chk("rstcol_x9", rd_data_b, '0);

    // Random soak against the behavioural model (starts from a reset)
    reset = 1'b0; tick();
    reset = 1'b1;
    for (int r = 0; r < 32; r++) mdl[r] = '0;
    for (int c = 0; c < 2000; c++) begin
      logic [W-1:0] ea, eb;
      reset     = ($urandom_range(31) != 0);
      wr_en     = $urandom_range(1);
      wr_addr   = 5'($urandom_range(31));
      wr_data   = {$urandom, $urandom};
      rd_addr_a = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      rd_addr_b = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      #1;
      ea = (rd_addr_a == 5'd31) ? '0 :
           (wr_en && reset && wr_addr == rd_addr_a && wr_addr != 5'd31) ? wr_data : mdl[rd_addr_a];
      eb = (rd_addr_b == 5'd31) ? '0 :
           (wr_en && reset && wr_addr == rd_addr_b && wr_addr != 5'd31) ? wr_data : mdl[rd_addr_b];
      chk("soak_a", rd_data_a, ea);
      chk("soak_b", rd_data_b, eb);
      if (!reset) begin
        for (int r = 0; r < 32; r++) mdl[r] = '0;
      end else if (wr_en && wr_addr != 5'd31) begin
        mdl[wr_addr] = wr_data;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
